// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: data width, reset PC, FSM encodings and the FIFO entry layout.
package fetch_unit_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
// Head visible the cycle after the push edge; push on full accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, prefetch FIFO toward decode, redirect flush.
// Request issues the cycle after IDLE; instruction valid the cycle after the ack edge.
// Stops requesting when the FIFO would be full; instr_ready low holds the head.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] req_addr;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   occ_after;
    fetch_entry_t    push_ent;
    fetch_entry_t    head_ent;

    assign fifo_pop  = instr_valid && instr_ready;
    assign fifo_push = (state == ST_WAIT) && mem_ack && !redirect_valid;
    assign occ_after = fifo_count + CW'(1) - CW'(fifo_pop);
    assign push_ent  = '{pc: pc, word: mem_rdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!redirect_valid && !fifo_full) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_valid)  state_nxt = mem_ack ? ST_IDLE : ST_DRAIN;
                else if (mem_ack)    state_nxt = (occ_after < DEPTH_C) ? ST_WAIT : ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The request address is registered separately so it holds through DRAIN
    // while pc already points at the redirect target.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc;
        case (state)
            ST_WAIT, ST_DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect_valid) pc_nxt = word_align(redirect_pc);
        else if (fifo_push) pc_nxt = pc + INSTR_BYTES;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            pc <= pc_nxt;
            if (state_nxt == ST_WAIT && (state != ST_WAIT || mem_ack))
                req_addr <= pc_nxt;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .pop_dat  (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head_ent.word;
    assign instr_pc    = head_ent.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr ^ 32'hDEAD_0000 combinationally.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(mem_req),     32'h0);
        chk({tag, "_addr"},  mem_addr,         32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, instr,            32'h0);
        chk({tag, "_pc"},    instr_pc,         32'h0);
    endtask

    // Called at a negedge; releases reset at the following negedge.
    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b1;
        mem_ack        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1 reset_n = 1'b0;
        #1;
        chk_reset_vals("rst");

        // Streaming: ack and ready tied high.
        @(negedge clk);
        mem_ack = 1'b1; instr_ready = 1'b1; reset_n = 1'b1;
        @(negedge clk);
        chk("s_req0",   32'(mem_req), 32'h1);
        chk("s_addr0",  mem_addr, 32'h0);
        chk("s_valid0", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("s_addr1",  mem_addr, 32'h4);
        chk("s_valid1", 32'(instr_valid), 32'h1);
        chk("s_pc1",    instr_pc, 32'h0);
        chk("s_instr1", instr, 32'hDEAD_0000);
        @(negedge clk);
        chk("s_addr2",  mem_addr, 32'h8);
        chk("s_pc2",    instr_pc, 32'h4);
        chk("s_instr2", instr, 32'hDEAD_0004);

        // Backpressure: FIFO fills with two entries, then requests stop.
        instr_ready = 1'b0; mem_ack = 1'b1;
        pulse_reset();
        @(negedge clk);
        chk("bp_req0",  32'(mem_req), 32'h1);
        chk("bp_addr0", mem_addr, 32'h0);
        @(negedge clk);
        chk("bp_addr1", mem_addr, 32'h4);
        chk("bp_pc1",   instr_pc, 32'h0);
        @(negedge clk);
        chk("bp_req_drop", 32'(mem_req), 32'h0);
        chk("bp_valid",    32'(instr_valid), 32'h1);
        chk("bp_head",     instr_pc, 32'h0);
        @(negedge clk);
        chk("bp_req_idle", 32'(mem_req), 32'h0);
        chk("bp_head2",    instr_pc, 32'h0);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_still", 32'(mem_req), 32'h0);
        chk("bp_head3",     instr_pc, 32'h4);
        @(negedge clk);
        chk("bp_resume_req",  32'(mem_req), 32'h1);
        chk("bp_resume_addr", mem_addr, 32'h8);
        chk("bp_empty",       32'(instr_valid), 32'h0);

        // Slow memory: ack after three request cycles.
        mem_ack = 1'b0; instr_ready = 1'b1;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lat_req%0d", i),  32'(mem_req), 32'h1);
            chk($sformatf("lat_addr%0d", i), mem_addr, 32'h0);
            chk($sformatf("lat_val%0d", i),  32'(instr_valid), 32'h0);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        chk("lat_valid", 32'(instr_valid), 32'h1);
        chk("lat_pc",    instr_pc, 32'h0);
        chk("lat_instr", instr, 32'hDEAD_0000);
        chk("lat_addr4", mem_addr, 32'h4);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lat_pop",   32'(instr_valid), 32'h0);
        chk("lat_hold4", mem_addr, 32'h4);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("dr_addr8", mem_addr, 32'h8);
        chk("dr_pc4",   instr_pc, 32'h4);

        // Redirect while the request to 0x8 is outstanding.
        mem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("dr_req_hold",  32'(mem_req), 32'h1);
        chk("dr_addr_hold", mem_addr, 32'h8);
        chk("dr_flushed",   32'(instr_valid), 32'h0);
        redirect_valid = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("dr_idle_req", 32'(mem_req), 32'h0);
        chk("dr_discard",  32'(instr_valid), 32'h0);
        chk("dr_newpc",    mem_addr, 32'h100);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("dr_req_new",  32'(mem_req), 32'h1);
        chk("dr_addr_new", mem_addr, 32'h100);
        @(negedge clk);
        chk("dr_first_valid", 32'(instr_valid), 32'h1);
        chk("dr_first_pc",    instr_pc, 32'h100);
        chk("dr_first_instr", instr, 32'hDEAD_0100);

        // Redirect together with ack of 0x104 and pop of 0x100.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("rap_empty", 32'(instr_valid), 32'h0);
        chk("rap_req",   32'(mem_req), 32'h0);
        chk("rap_addr",  mem_addr, 32'h200);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rap_addr_new", mem_addr, 32'h200);
        chk("rap_no_stale", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("rap_pc",    instr_pc, 32'h200);
        chk("rap_instr", instr, 32'hDEAD_0200);

        // Address wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        chk("wr_idle",  32'(mem_req), 32'h0);
        chk("wr_flush", 32'(instr_valid), 32'h0);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wr_addr0", mem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("wr_addr1", mem_addr, 32'hFFFF_FFFC);
        chk("wr_pc0",   instr_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("wr_addr2", mem_addr, 32'h0);
        chk("wr_pc1",   instr_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wr_addr3",  mem_addr, 32'h4);
        chk("wr_instr2", instr, 32'hDEAD_0000);
        chk("wr_req",    32'(mem_req), 32'h1);

        // Asynchronous reset in the middle of a request.
        mem_ack = 1'b0; instr_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        mem_ack = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_req1",  32'(mem_req), 32'h1);
        chk("arst_addr1", mem_addr, 32'h0);
        chk("arst_val1",  32'(instr_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
